demux_1to2_for_y: RTL and testbench

DEMUX_1TO2_FOR_Y -- requirements
Module: demux_1to2_for_y

---
 rtl/demux_1to2_for_y.sv | 127 ++++++++++++
 tb/tb_demux_1to2_for_y.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/demux_1to2_for_y.sv
// Handshaked 1-to-2 demux with a bias-check select and a done pulse once both outputs are written.
// Optional: define ILLEGAL_SEL_CHECK_EN to flag s=11 transfers as errors instead of dropping them.
module demux_1to2_for_y #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic             bias_seen,
  output logic             err,
  output logic             done,
  output logic [3:0]       wr_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] o1_q, o1_d;
  logic [WIDTH-1:0] o2_q, o2_d;
  logic             w1_q, w1_d;
  logic             w2_q, w2_d;
  logic             bias_q, bias_d;
  logic             err_q, err_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      o1_q    <= '0;
      o2_q    <= '0;
      w1_q    <= 1'b0;
      w2_q    <= 1'b0;
      bias_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      o1_q    <= o1_d;
      o2_q    <= o2_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      bias_q  <= bias_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    o1_d    = o1_q;
    o2_d    = o2_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    bias_d  = bias_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    legal   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = HOLD;
          case (s)
            2'b00: begin
              o1_d  = d;
              w1_d  = 1'b1;
              legal = 1'b1;
            end
            2'b01: begin
              o2_d  = d;
              w2_d  = 1'b1;
              legal = 1'b1;
            end
            2'b10: begin
              if (d == WIDTH'(1)) begin
                bias_d = 1'b1;
                legal  = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin
`ifdef ILLEGAL_SEL_CHECK_EN
              err_d = 1'b1;
`else
              err_d = err_q;
`endif
            end
          endcase
          // Count saturates so a long run of writes never wraps back to small values.
          if (legal && (cnt_q != 4'hF)) begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      HOLD: begin
        state_d = (w1_q && w2_q) ? DONE : IDLE;
      end
      DONE: begin
        state_d = IDLE;
        w1_d    = 1'b0;
        w2_d    = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign done      = (state_q == DONE);
  assign o1        = o1_q;
  assign o2        = o2_q;
  assign bias_seen = bias_q;
  assign err       = err_q;
  assign wr_count  = cnt_q;

endmodule

// File: tb/tb_demux_1to2_for_y.sv
// Directed self-checking bench for demux_1to2_for_y; inputs change and outputs are sampled on the falling edge.
module tb_demux_1to2_for_y;

  localparam int WIDTH = 7;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d;
  logic [1:0]       s;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic             bias_seen;
  logic             err;
  logic             done;
  logic [3:0]       wr_count;

  int testCount = 0;
  int failCount = 0;
  logic doneSeen;

  demux_1to2_for_y #(.WIDTH(WIDTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .d(d),
    .s(s),
    .o1(o1),
    .o2(o2),
    .bias_seen(bias_seen),
    .err(err),
    .done(done),
    .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Called on a falling edge; waits (bounded) for in_ready, then presents one word for one edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] dv, input logic [1:0] sv);
    int n = 0;
    while (!in_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    d        = dv;
    s        = sv;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    d        = '0;
    s        = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    d        = '0;
    s        = 2'b00;
    doReset();

    checkOutput("rst_o1", 32'(o1), 32'h0);
    checkOutput("rst_o2", 32'(o2), 32'h0);
    checkOutput("rst_bias", 32'(bias_seen), 32'h0);
    checkOutput("rst_err", 32'(err), 32'h0);
    checkOutput("rst_done", 32'(done), 32'h0);
    checkOutput("rst_cnt", 32'(wr_count), 32'h0);
    checkOutput("rst_ready", 32'(in_ready), 32'h1);

    // Two-destination write followed by the done pulse
    applyStimulus(7'h15, 2'b00);
    checkOutput("w1_o1", 32'(o1), 32'h15);
    checkOutput("w1_ready_hold", 32'(in_ready), 32'h0);
    checkOutput("w1_done", 32'(done), 32'h0);
    @(negedge clk);
    checkOutput("w1_idle_done", 32'(done), 32'h0);
    checkOutput("w1_idle_ready", 32'(in_ready), 32'h1);
    applyStimulus(7'h2A, 2'b01);
    checkOutput("w2_o2", 32'(o2), 32'h2A);
    checkOutput("w2_o1_kept", 32'(o1), 32'h15);
    checkOutput("w2_cnt", 32'(wr_count), 32'h2);
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'h1);
    checkOutput("done_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    checkOutput("done_gone", 32'(done), 32'h0);
    checkOutput("done_idle_ready", 32'(in_ready), 32'h1);
    applyStimulus(7'h33, 2'b00);
    @(negedge clk);
    checkOutput("w_cleared_nodone", 32'(done), 32'h0);
    checkOutput("w_cleared_ready", 32'(in_ready), 32'h1);

    // Bias check: d==1 is legal, any other value flags an error
    doReset();
    applyStimulus(7'h01, 2'b10);
    checkOutput("bias_set", 32'(bias_seen), 32'h1);
    checkOutput("bias_err", 32'(err), 32'h0);
    checkOutput("bias_cnt", 32'(wr_count), 32'h1);
    @(negedge clk);
    applyStimulus(7'h05, 2'b10);
    checkOutput("badbias_err", 32'(err), 32'h1);
    checkOutput("badbias_cnt", 32'(wr_count), 32'h1);
    checkOutput("badbias_o1", 32'(o1), 32'h0);
    checkOutput("badbias_sticky", 32'(bias_seen), 32'h1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("err_sticky", 32'(err), 32'h1);

    // in_valid held high across three words
    doReset();
    in_valid = 1'b1;
    d        = 7'h11;
    s        = 2'b00;
    @(negedge clk);
    checkOutput("cont1_ready", 32'(in_ready), 32'h0);
    checkOutput("cont1_cnt", 32'(wr_count), 32'h1);
    d = 7'h22;
    s = 2'b01;
    @(negedge clk);
    checkOutput("cont2_ready", 32'(in_ready), 32'h1);
    checkOutput("cont2_cnt", 32'(wr_count), 32'h1);
    @(negedge clk);
    checkOutput("cont3_ready", 32'(in_ready), 32'h0);
    checkOutput("cont3_cnt", 32'(wr_count), 32'h2);
    checkOutput("cont3_o2", 32'(o2), 32'h22);
    d = 7'h0C;
    s = 2'b00;
    @(negedge clk);
    checkOutput("cont4_ready", 32'(in_ready), 32'h0);
    checkOutput("cont4_done", 32'(done), 32'h1);
    @(negedge clk);
    checkOutput("cont5_ready", 32'(in_ready), 32'h1);
    checkOutput("cont5_o1_kept", 32'(o1), 32'h11);
    checkOutput("cont5_cnt", 32'(wr_count), 32'h2);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("cont6_o1", 32'(o1), 32'h0C);
    checkOutput("cont6_cnt", 32'(wr_count), 32'h3);
    @(negedge clk);

    // Eighteen writes to o1: counter saturates, done never fires
    doReset();
    doneSeen = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      applyStimulus(7'(i), 2'b00);
      doneSeen = doneSeen | done;
      @(negedge clk);
      doneSeen = doneSeen | done;
    end
    checkOutput("sat_cnt", 32'(wr_count), 32'hF);
    checkOutput("sat_o1", 32'(o1), 32'h12);
    checkOutput("sat_nodone", 32'(doneSeen), 32'h0);

    // Reset in HOLD with both written flags set
    doReset();
    applyStimulus(7'h15, 2'b00);
    @(negedge clk);
    applyStimulus(7'h2A, 2'b01);
    rst = 1'b1;
    #2;
    checkOutput("abort_o1", 32'(o1), 32'h0);
    checkOutput("abort_o2", 32'(o2), 32'h0);
    checkOutput("abort_cnt", 32'(wr_count), 32'h0);
    checkOutput("abort_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    checkOutput("abort_nodone", 32'(done), 32'h0);
    rst = 1'b0;
    applyStimulus(7'h40, 2'b01);
    checkOutput("post_abort_o2", 32'(o2), 32'h40);
    checkOutput("post_abort_cnt", 32'(wr_count), 32'h1);
    @(negedge clk);
    checkOutput("post_abort_nodone", 32'(done), 32'h0);

    // Illegal select s=11
    doReset();
    applyStimulus(7'h7F, 2'b11);
`ifdef ILLEGAL_SEL_CHECK_EN
    checkOutput("ill_err", 32'(err), 32'h1);
`else
    checkOutput("ill_err", 32'(err), 32'h0);
`endif
    checkOutput("ill_o1", 32'(o1), 32'h0);
    checkOutput("ill_o2", 32'(o2), 32'h0);
    checkOutput("ill_cnt", 32'(wr_count), 32'h0);
    checkOutput("ill_hold", 32'(in_ready), 32'h0);
    @(negedge clk);
    checkOutput("ill_idle", 32'(in_ready), 32'h1);
    checkOutput("ill_nodone", 32'(done), 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
